spi_ram_ctrl: RTL

- SPI slave front-end and sequencer for the single-port command RAM (10-bit command word in, 8-bit read data out).
- Deserialises MOSI frames into 10-bit words and issues them to the RAM with a one-cycle rx_valid strobe.
- Tracks the read-address/read-data protocol and serialises RAM read data back on MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper.

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/spi_tx_shifter.sv | 53 +++++
 rtl/spi_ram_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI command-RAM front-end.
package spi_ram_pkg;

   // Default widths: 2 command bits + 8 payload bits in, 8 data bits out
   localparam int FRAME_W_DEF = 10;
   localparam int DATA_W_DEF  = 8;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   // Command field (frame bits 9:8) as interpreted by the RAM
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Only the command MSB steers the sequencer; bit 8 is left to the RAM
   function automatic logic is_read_cmd(input logic cmd_msb);
      return cmd_msb == CMD_RD_ADDR[1];
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser driving MISO, with a busy flag.
module spi_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_miso,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] r_sr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_miso;
   logic              r_busy;

   // Load presents the MSB at once; the remaining bits follow one per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_miso <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_abort) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_miso <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_load && !r_busy) begin
         r_miso <= i_data[DATA_W-1];
         r_sr   <= {i_data[DATA_W-2:0], 1'b0};
         r_cnt  <= CNT_W'(DATA_W - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt != '0) begin
            r_miso <= r_sr[DATA_W-1];
            r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
            r_cnt  <= r_cnt - 1'b1;
         end else begin
            r_miso <= 1'b0;
            r_busy <= 1'b0;
         end
      end
   end

   assign o_miso = r_miso;
   assign o_busy = r_busy;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI slave front-end: deserialises command frames for the RAM and
// returns RAM read data on MISO.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
);

   localparam int CNT_W = $clog2(FRAME_W + 1);
   // Count value on the edge that samples frame bit 0, and the saturated end value
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FRAME_W);

   state_t             r_state;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [FRAME_W-2:0] r_shift;
   logic [FRAME_W-1:0] r_rx_data;
   logic               r_rx_valid;
   logic               r_rd_addr_seen;
   logic               r_tx_started;

   logic               w_tx_load;
   logic               w_tx_busy;
   logic               w_miso;

   // Read data is accepted once per READ_DATA frame, only after the command completed
   assign w_tx_load = !SS_n && (r_state == READ_DATA) && (r_bit_cnt == C_FULL) &&
                      tx_valid && !r_tx_started && !w_tx_busy;

   // Sequencer and MOSI deserialiser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_bit_cnt      <= '0;
         r_shift        <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rd_addr_seen <= 1'b0;
         r_tx_started   <= 1'b0;
      end else if (SS_n) begin
         // Deselect discards any partial frame; rd_addr_seen survives
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_rx_valid   <= 1'b0;
         r_tx_started <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_state   <= CHK_CMD;
               r_bit_cnt <= '0;
            end
            CHK_CMD: begin
               r_shift   <= {r_shift[FRAME_W-3:0], MOSI};
               r_bit_cnt <= CNT_W'(1);
               if (!is_read_cmd(MOSI)) begin
                  r_state <= WRITE;
               end else if (r_rd_addr_seen) begin
                  r_state <= READ_DATA;
               end else begin
                  r_state <= READ_ADD;
               end
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (r_bit_cnt != C_FULL) begin
                  r_shift   <= {r_shift[FRAME_W-3:0], MOSI};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == C_LAST) begin
                     r_rx_data  <= {r_shift, MOSI};
                     r_rx_valid <= 1'b1;
                     if (r_state == READ_ADD) begin
                        r_rd_addr_seen <= 1'b1;
                     end
                     if (r_state == READ_DATA) begin
                        r_rd_addr_seen <= 1'b0;
                     end
                  end
               end
               if (w_tx_load) begin
                  r_tx_started <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   spi_tx_shifter #(
      .DATA_W (DATA_W)
   ) u_tx_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tx_load),
      .i_abort (SS_n),
      .i_data  (tx_data),
      .o_miso  (w_miso),
      .o_busy  (w_tx_busy)
   );

   assign MISO     = w_miso;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule
